// File: rtl/scene_compositor_pkg.sv
// Shared definitions for the scene compositor: screen encodings and the
// RRRGGGBB colour byte layout used by every layer and by the pixel output.
package scene_compositor_pkg;

    typedef enum logic [1:0] {
        SCR_TITLE   = 2'd0,
        SCR_PLAY    = 2'd1,
        SCR_OVER    = 2'd2,
        SCR_HISCORE = 2'd3
    } screen_e;

    localparam int COLOR_W = 8;
    localparam int R_MSB   = 7;
    localparam int R_LSB   = 5;
    localparam int G_MSB   = 4;
    localparam int G_LSB   = 2;
    localparam int B_MSB   = 1;
    localparam int B_LSB   = 0;

    // Colour field extraction from a packed RRRGGGBB byte
    function automatic logic [2:0] color_r(input logic [COLOR_W-1:0] c);
        return c[R_MSB:R_LSB];
    endfunction

    function automatic logic [2:0] color_g(input logic [COLOR_W-1:0] c);
        return c[G_MSB:G_LSB];
    endfunction

    function automatic logic [1:0] color_b(input logic [COLOR_W-1:0] c);
        return c[B_MSB:B_LSB];
    endfunction

endpackage

// File: rtl/scene_compositor_layer_mixer.sv
// Combinational layer mixer: masks each 8-bit layer with its enable bit and
// reduces the enabled layers either by bitwise OR or by lowest-index priority.
module layer_mixer
    import scene_compositor_pkg::*;
#(
    parameter int N_LAYERS      = 8,
    parameter int PRIORITY_MODE = 0
) (
    input  logic [N_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [N_LAYERS-1:0]         mask,
    output logic [COLOR_W-1:0]          pixel
);

    logic [COLOR_W-1:0] enabled;
    logic               found;

    // Walk the layers from index 0 upward; OR mode accumulates every enabled
    // layer, priority mode keeps the first enabled layer that is non-zero.
    always_comb begin
        pixel   = '0;
        found   = 1'b0;
        enabled = '0;
        for (int j = 0; j < N_LAYERS; j++) begin
            enabled = layer_color[COLOR_W*j +: COLOR_W] & {COLOR_W{mask[j]}};
            if (PRIORITY_MODE == 0) begin
                pixel = pixel | enabled;
            end else if (!found && (enabled != '0)) begin
                pixel = enabled;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scene_compositor.sv
// Game scene controller and pixel compositor: sequences the title, play,
// game-over and high-score screens, keeps lives/score/high score and the
// post-hit invulnerability window, and registers the composited pixel.
module scene_compositor
    import scene_compositor_pkg::*;
#(
    parameter int N_LAYERS       = 8,
    parameter int START_LIVES    = 4,
    parameter int LIVES_W        = 4,
    parameter int SCORE_W        = 7,
    parameter int INVULN_FRAMES  = 30,
    parameter int HISCORE_FRAMES = 180,
    parameter int PRIORITY_MODE  = 0,
    parameter logic [N_LAYERS-1:0] TITLE_MASK   = '1,
    parameter logic [N_LAYERS-1:0] PLAY_MASK    = '1,
    parameter logic [N_LAYERS-1:0] OVER_MASK    = '1,
    parameter logic [N_LAYERS-1:0] HISCORE_MASK = '1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        action_pulse,
    input  logic                        hit_pulse,
    input  logic                        score_pulse,
    input  logic                        frame_tick,
    input  logic [N_LAYERS*8-1:0]       layer_color,
    output logic [1:0]                  screen,
    output logic                        new_game,
    output logic [LIVES_W-1:0]          lives,
    output logic [SCORE_W-1:0]          score,
    output logic [SCORE_W-1:0]          high_score,
    output logic                        invuln,
    output logic [2:0]                  r,
    output logic [2:0]                  g,
    output logic [1:0]                  b
);

    localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam int HS_W  = (HISCORE_FRAMES > 0) ? $clog2(HISCORE_FRAMES + 1) : 1;

    screen_e              screen_q, screen_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   high_score_q, high_score_d;
    logic                 invuln_q, invuln_d;
    logic [INV_W-1:0]     inv_cnt_q, inv_cnt_d;
    logic [HS_W-1:0]      hs_cnt_q, hs_cnt_d;
    logic                 new_game_q, new_game_d;
    logic [COLOR_W-1:0]   pix_q, pix_d;

    logic [N_LAYERS-1:0]  mask;
    logic [COLOR_W-1:0]   mixed_pixel;
    logic                 hit_ok;
    logic                 hs_done;

    // A hit only counts while playing and outside the invulnerability window
    assign hit_ok  = (screen_q == SCR_PLAY) && hit_pulse && !invuln_q;
    assign hs_done = frame_tick && ((32'(hs_cnt_q) + 32'd1) >= 32'(HISCORE_FRAMES));

    // Layer enables follow the registered screen, so a screen change reaches
    // the pixel one cycle after the screen itself updates
    always_comb begin
        mask = TITLE_MASK;
        case (screen_q)
            SCR_TITLE:   mask = TITLE_MASK;
            SCR_PLAY:    mask = PLAY_MASK;
            SCR_OVER:    mask = OVER_MASK;
            SCR_HISCORE: mask = HISCORE_MASK;
            default:     mask = TITLE_MASK;
        endcase
    end

    layer_mixer #(
        .N_LAYERS      (N_LAYERS),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_layer_mixer (
        .layer_color (layer_color),
        .mask        (mask),
        .pixel       (mixed_pixel)
    );

    // Screen sequencing plus lives, score, high score and timers for the next frame
    always_comb begin
        screen_d     = screen_q;
        lives_d      = lives_q;
        score_d      = score_q;
        high_score_d = high_score_q;
        invuln_d     = invuln_q;
        inv_cnt_d    = inv_cnt_q;
        hs_cnt_d     = '0;
        new_game_d   = 1'b0;
        pix_d        = mixed_pixel;

        if (invuln_q && frame_tick) begin
            inv_cnt_d = inv_cnt_q - INV_W'(1);
            if (inv_cnt_q == INV_W'(1)) begin
                invuln_d = 1'b0;
            end
        end

        case (screen_q)
            SCR_TITLE: begin
                if (action_pulse) begin
                    screen_d   = SCR_PLAY;
                    new_game_d = 1'b1;
                    lives_d    = LIVES_W'(START_LIVES);
                    score_d    = '0;
                    invuln_d   = 1'b0;
                    inv_cnt_d  = '0;
                end
            end
            SCR_PLAY: begin
                if (score_pulse && (score_q != '1)) begin
                    score_d = score_q + SCORE_W'(1);
                end
                if (hit_ok) begin
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                    if (INVULN_FRAMES > 0) begin
                        invuln_d  = 1'b1;
                        inv_cnt_d = INV_W'(INVULN_FRAMES);
                    end
                    if (lives_q <= LIVES_W'(1)) begin
                        screen_d = SCR_OVER;
                    end
                end
            end
            SCR_OVER: begin
                if (action_pulse) begin
                    if (score_q > high_score_q) begin
                        high_score_d = score_q;
                        screen_d     = SCR_HISCORE;
                    end else begin
                        screen_d = SCR_TITLE;
                    end
                end
            end
            SCR_HISCORE: begin
                hs_cnt_d = frame_tick ? (hs_cnt_q + HS_W'(1)) : hs_cnt_q;
                if (action_pulse || hs_done) begin
                    screen_d = SCR_TITLE;
                end
            end
            default: screen_d = SCR_TITLE;
        endcase
    end

    // State and pixel registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            screen_q     <= SCR_TITLE;
            lives_q      <= LIVES_W'(START_LIVES);
            score_q      <= '0;
            high_score_q <= '0;
            invuln_q     <= 1'b0;
            inv_cnt_q    <= '0;
            hs_cnt_q     <= '0;
            new_game_q   <= 1'b0;
            pix_q        <= '0;
        end else begin
            screen_q     <= screen_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
            invuln_q     <= invuln_d;
            inv_cnt_q    <= inv_cnt_d;
            hs_cnt_q     <= hs_cnt_d;
            new_game_q   <= new_game_d;
            pix_q        <= pix_d;
        end
    end

    assign screen     = screen_q;
    assign new_game   = new_game_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign high_score = high_score_q;
    assign invuln     = invuln_q;
    assign r          = color_r(pix_q);
    assign g          = color_g(pix_q);
    assign b          = color_b(pix_q);

endmodule

// File: tb/tb_scene_compositor.sv
// Testbench for scene_compositor: drives directed game scenarios followed by
// random pulses and layer colours, comparing every cycle against a
// game-level model of the screens, lives, score and compositing rules.
module tb_scene_compositor;

   localparam int START_LIVES    = 4;
   localparam int SCORE_MAX      = 127;
   localparam int INVULN_FRAMES  = 30;
   localparam int HISCORE_FRAMES = 180;
   localparam logic [7:0] M_TITLE = 8'h81;
   localparam logic [7:0] M_PLAY  = 8'h03;
   localparam logic [7:0] M_OVER  = 8'h0C;
   localparam logic [7:0] M_HI    = 8'hF0;

   logic        clk;
   logic        reset;
   logic        action_pulse;
   logic        hit_pulse;
   logic        score_pulse;
   logic        frame_tick;
   logic [63:0] layer_color;

   logic [1:0]  screen, screenPri;
   logic        newGame, newGamePri;
   logic [3:0]  lives, livesPri;
   logic [6:0]  score, scorePri;
   logic [6:0]  highScore, highScorePri;
   logic        invuln, invulnPri;
   logic [2:0]  rOr, gOr, rPri, gPri;
   logic [1:0]  bOr, bPri;

   int nChecks;
   int nFails;

   int   mScreen, mLives, mScore, mHi, mInvLeft, mHsTicks;
   bit   mNewGame;
   logic [7:0] mPixOr, mPixPri;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   scene_compositor #(
      .N_LAYERS(8), .START_LIVES(START_LIVES), .LIVES_W(4), .SCORE_W(7),
      .INVULN_FRAMES(INVULN_FRAMES), .HISCORE_FRAMES(HISCORE_FRAMES), .PRIORITY_MODE(0),
      .TITLE_MASK(M_TITLE), .PLAY_MASK(M_PLAY), .OVER_MASK(M_OVER), .HISCORE_MASK(M_HI)
   ) u_dut_or (
      .clk(clk), .reset(reset), .action_pulse(action_pulse), .hit_pulse(hit_pulse),
      .score_pulse(score_pulse), .frame_tick(frame_tick), .layer_color(layer_color),
      .screen(screen), .new_game(newGame), .lives(lives), .score(score),
      .high_score(highScore), .invuln(invuln), .r(rOr), .g(gOr), .b(bOr)
   );

   scene_compositor #(
      .N_LAYERS(8), .START_LIVES(START_LIVES), .LIVES_W(4), .SCORE_W(7),
      .INVULN_FRAMES(INVULN_FRAMES), .HISCORE_FRAMES(HISCORE_FRAMES), .PRIORITY_MODE(1),
      .TITLE_MASK(M_TITLE), .PLAY_MASK(M_PLAY), .OVER_MASK(M_OVER), .HISCORE_MASK(M_HI)
   ) u_dut_pri (
      .clk(clk), .reset(reset), .action_pulse(action_pulse), .hit_pulse(hit_pulse),
      .score_pulse(score_pulse), .frame_tick(frame_tick), .layer_color(layer_color),
      .screen(screenPri), .new_game(newGamePri), .lives(livesPri), .score(scorePri),
      .high_score(highScorePri), .invuln(invulnPri), .r(rPri), .g(gPri), .b(bPri)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pixel the screen's enabled layers should produce under each mixing rule
   function automatic logic [7:0] compose(input int scr, input logic [63:0] colors, input bit prio);
      logic [7:0] m;
      logic [7:0] res;
      logic [7:0] layerByte;
      case (scr)
         0: m = M_TITLE;
         1: m = M_PLAY;
         2: m = M_OVER;
         default: m = M_HI;
      endcase
      res = 8'h00;
      for (int j = 0; j < 8; j++) begin
         layerByte = m[j] ? colors[8*j +: 8] : 8'h00;
         if (!prio) res = res | layerByte;
         else if (res == 8'h00) res = layerByte;
      end
      return res;
   endfunction

   // Game rules applied to one clock's worth of inputs
   task automatic modelStep(input bit rst, input bit act, input bit hit, input bit sc,
                            input bit ft, input logic [63:0] colors);
      int oldScreen;
      int oldInv;
      if (rst) begin
         mScreen = 0; mLives = START_LIVES; mScore = 0; mHi = 0;
         mInvLeft = 0; mHsTicks = 0; mNewGame = 0; mPixOr = 8'h00; mPixPri = 8'h00;
         return;
      end
      oldScreen = mScreen;
      oldInv    = mInvLeft;
      mPixOr    = compose(oldScreen, colors, 1'b0);
      mPixPri   = compose(oldScreen, colors, 1'b1);
      mNewGame  = 0;
      if (ft && mInvLeft > 0) mInvLeft--;
      case (oldScreen)
         0: if (act) begin
               mScreen = 1; mNewGame = 1; mLives = START_LIVES; mScore = 0; mInvLeft = 0;
            end
         1: begin
               if (sc && mScore < SCORE_MAX) mScore++;
               if (hit && oldInv == 0) begin
                  if (mLives == 1) mScreen = 2;
                  if (mLives > 0) mLives--;
                  mInvLeft = INVULN_FRAMES;
               end
            end
         2: if (act) begin
               if (mScore > mHi) begin
                  mHi = mScore; mScreen = 3; mHsTicks = 0;
               end else begin
                  mScreen = 0;
               end
            end
         default: begin
               if (ft) mHsTicks++;
               if (act || (ft && mHsTicks >= HISCORE_FRAMES)) mScreen = 0;
            end
      endcase
   endtask

   function automatic logic [63:0] randColors();
      logic [63:0] c;
      for (int j = 0; j < 8; j++) begin
         c[8*j +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      end
      return c;
   endfunction

   // Drive one cycle of inputs, advance the model, and compare after the edge
   task automatic applyStimulus(input bit rst, input bit act, input bit hit, input bit sc,
                                input bit ft, input logic [63:0] colors);
      reset        = rst;
      action_pulse = act;
      hit_pulse    = hit;
      score_pulse  = sc;
      frame_tick   = ft;
      layer_color  = colors;
      modelStep(rst, act, hit, sc, ft, colors);
      @(posedge clk);
      #1;
      checkOutput("screen",     32'(screen),              32'(mScreen));
      checkOutput("new_game",   32'(newGame),             32'(mNewGame));
      checkOutput("lives",      32'(lives),               32'(mLives));
      checkOutput("score",      32'(score),               32'(mScore));
      checkOutput("high_score", 32'(highScore),           32'(mHi));
      checkOutput("invuln",     32'(invuln),              32'(mInvLeft > 0));
      checkOutput("pixel_or",   32'({rOr, gOr, bOr}),     32'(mPixOr));
      checkOutput("pixel_pri",  32'({rPri, gPri, bPri}),  32'(mPixPri));
      checkOutput("pri_screen", 32'(screenPri),           32'(mScreen));
   endtask

   // Directed game scenarios, then a long random run
   initial begin
      nChecks = 0;
      nFails  = 0;
      reset = 1'b1; action_pulse = 1'b0; hit_pulse = 1'b0;
      score_pulse = 1'b0; frame_tick = 1'b0; layer_color = '0;

      applyStimulus(1, 0, 0, 0, 0, randColors());
      applyStimulus(1, 0, 0, 0, 0, randColors());
      checkOutput("rst_screen", 32'(screen), 32'd0);
      checkOutput("rst_lives",  32'(lives),  32'd4);
      checkOutput("rst_pixel",  32'({rOr, gOr, bOr}), 32'd0);

      // Start a game
      applyStimulus(0, 0, 0, 0, 0, randColors());
      applyStimulus(0, 1, 0, 0, 0, randColors());
      checkOutput("start_screen", 32'(screen),  32'd1);
      checkOutput("start_pulse",  32'(newGame), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, randColors());
      checkOutput("pulse_drop",   32'(newGame), 32'd0);

      // Two-layer OR versus priority, then layer 0 cleared
      applyStimulus(0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_1CE0);
      checkOutput("mix_or",  32'({rOr, gOr, bOr}),    32'h0FC);
      checkOutput("mix_pri", 32'({rPri, gPri, bPri}), 32'h0E0);
      applyStimulus(0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_1C00);
      checkOutput("mix_l1", 32'({rPri, gPri, bPri}), 32'h01C);

      // Score five, then lose all lives with well-spaced hits
      for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 0, randColors());
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 1, 0, 0, randColors());
         for (int t = 0; t < 35; t++) applyStimulus(0, 0, 0, 0, 1, randColors());
      end
      checkOutput("over_screen", 32'(screen), 32'd2);
      checkOutput("over_lives",  32'(lives),  32'd0);
      checkOutput("over_score",  32'(score),  32'd5);

      // New best goes to the high-score screen, which times out by itself
      applyStimulus(0, 1, 0, 0, 0, randColors());
      checkOutput("hi_screen", 32'(screen),    32'd3);
      checkOutput("hi_value",  32'(highScore), 32'd5);
      for (int t = 0; t < 200; t++) applyStimulus(0, 0, 0, 0, 1, randColors());
      checkOutput("hi_timeout", 32'(screen), 32'd0);

      // Second game: hit ignored during invulnerability, lower score skips high score
      applyStimulus(0, 1, 0, 0, 0, randColors());
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0, randColors());
      applyStimulus(0, 0, 1, 0, 0, randColors());
      for (int t = 0; t < 10; t++) applyStimulus(0, 0, 0, 0, 1, randColors());
      applyStimulus(0, 0, 1, 0, 0, randColors());
      checkOutput("inv_lives", 32'(lives),  32'd3);
      checkOutput("inv_high",  32'(invuln), 32'd1);
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 35; t++) applyStimulus(0, 0, 0, 0, 1, randColors());
         applyStimulus(0, 0, 1, 0, 0, randColors());
      end
      applyStimulus(0, 1, 0, 0, 0, randColors());
      checkOutput("low_title", 32'(screen),    32'd0);
      checkOutput("low_hi",    32'(highScore), 32'd5);

      // Third game: hit and score together, then saturate the score
      applyStimulus(0, 1, 0, 0, 0, randColors());
      applyStimulus(0, 0, 1, 1, 0, randColors());
      checkOutput("both_score", 32'(score), 32'd1);
      checkOutput("both_lives", 32'(lives), 32'd3);
      for (int k = 0; k < 135; k++) applyStimulus(0, 0, 0, 1, 0, randColors());
      checkOutput("sat_score", 32'(score), 32'd127);

      // Reset in the middle of a game
      applyStimulus(1, 0, 0, 0, 0, randColors());
      checkOutput("mid_rst_screen", 32'(screen),  32'd0);
      checkOutput("mid_rst_pulse",  32'(newGame), 32'd0);

      // Random pulses and colours
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 499) == 0,
                       $urandom_range(0, 19) == 0,
                       $urandom_range(0, 14) == 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0,
                       randColors());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
